sad_search_ctrl: RTL and testbench

SAD_SEARCH_CTRL -- requirements
Module: sad_search_ctrl

---
 rtl/sad_search_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_sad_search_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_search_ctrl.sv
// sad_search_ctrl
// ---------------------------------------------------------------------------
// Sequences a sum-of-absolute-differences search over total_count candidate
// positions and folds the returned SAD values into a running minimum.
//
// Each issue beat covers NUM_LANES consecutive candidates, base..base+3. Lane
// k of a beat is live when base+k < total_count. Result beats come back from
// the SAD pipeline some cycles later, carrying a value and an index per lane.
// The beat flagged with res_trigger is the pipelined copy of issue_last, and
// it finalises the search.
//
// Handshake: there is no backpressure anywhere. The controller emits one beat
// on every ISSUE cycle. A result beat is consumed on every cycle that
// res_valid is high while the state is ISSUE or DRAIN; in any other state it
// is dropped.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   start, total_count  request a search of total_count candidates (IDLE only)
//   issue_*             issue beat: valid, base index, lane mask, last flag
//   res_*               result beat: valid, 4x14b values, 4x16b indices, trigger
//   busy, done          busy in ISSUE/DRAIN; one-cycle done pulse
//   best_value/index    minimum SAD found (lowest index wins ties)
//   dbg_state           current FSM state (0 IDLE, 1 ISSUE, 2 DRAIN, 3 DONE)
// ---------------------------------------------------------------------------
module sad_search_ctrl #(
    parameter int NUM_LANES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [15:0]               total_count,
    output logic                      issue_valid,
    output logic [15:0]               issue_index,
    output logic [NUM_LANES-1:0]      issue_mask,
    output logic                      issue_last,
    input  logic                      res_valid,
    input  logic [14*NUM_LANES-1:0]   res_value,
    input  logic [16*NUM_LANES-1:0]   res_index,
    input  logic                      res_trigger,
    output logic                      busy,
    output logic                      done,
    output logic [13:0]               best_value,
    output logic [15:0]               best_index,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [15:0]            total_q, total_d;
    logic                   issue_valid_q, issue_valid_d;
    logic [15:0]            issue_index_q, issue_index_d;  // doubles as base
    logic [NUM_LANES-1:0]   issue_mask_q, issue_mask_d;
    logic                   issue_last_q, issue_last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [13:0]            best_value_q, best_value_d;
    logic [15:0]            best_index_q, best_index_d;

    logic [15:0]            next_base;
    logic [13:0]            lane_value;
    logic [15:0]            lane_index;

    // Comparisons are done at 17 bits so base+k never wraps near 16'hFFFF.
    function automatic logic [NUM_LANES-1:0] lane_mask(input logic [15:0] base,
                                                       input logic [15:0] total);
        logic [NUM_LANES-1:0] m;
        m = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            m[k] = ({1'b0, base} + 17'(k)) < {1'b0, total};
        end
        return m;
    endfunction

    function automatic logic beat_is_last(input logic [15:0] base,
                                          input logic [15:0] total);
        return ({1'b0, base} + 17'(NUM_LANES)) >= {1'b0, total};
    endfunction

    assign next_base = issue_index_q + 16'(NUM_LANES);

    always_comb begin
        state_d       = state_q;
        total_d       = total_q;
        issue_valid_d = 1'b0;
        issue_index_d = issue_index_q;
        issue_mask_d  = '0;
        issue_last_d  = 1'b0;
        done_d        = 1'b0;
        best_value_d  = best_value_q;
        best_index_d  = best_index_q;
        lane_value    = '0;
        lane_index    = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    total_d      = total_count;
                    best_value_d = 14'h3FFF;
                    best_index_d = 16'hFFFF;
                    if (total_count != 16'd0) begin
                        // Registered issue outputs: beat 0 appears the cycle
                        // after start is accepted.
                        state_d       = S_ISSUE;
                        issue_valid_d = 1'b1;
                        issue_index_d = 16'd0;
                        issue_mask_d  = lane_mask(16'd0, total_count);
                        issue_last_d  = beat_is_last(16'd0, total_count);
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (issue_last_q) begin
                    state_d = S_DRAIN;
                end else begin
                    issue_valid_d = 1'b1;
                    issue_index_d = next_base;
                    issue_mask_d  = lane_mask(next_base, total_q);
                    issue_last_d  = beat_is_last(next_base, total_q);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase

        // Result folding: lanes are scanned 0..3 against the running best,
        // so on equal values the earlier (lower) index survives.
        if (res_valid && (state_q == S_ISSUE || state_q == S_DRAIN)) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                lane_value = res_value[14*k +: 14];
                lane_index = res_index[16*k +: 16];
                if ((lane_index < total_q) &&
                    ((lane_value < best_value_d) ||
                     (lane_value == best_value_d && lane_index < best_index_d))) begin
                    best_value_d = lane_value;
                    best_index_d = lane_index;
                end
            end
            // In ISSUE a trigger is only meaningful alongside the final beat.
            if (res_trigger && (state_q == S_DRAIN || issue_last_q)) begin
                state_d       = S_DONE;
                done_d        = 1'b1;
                issue_valid_d = 1'b0;
                issue_mask_d  = '0;
                issue_last_d  = 1'b0;
            end
        end

        busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            total_q       <= 16'd0;
            issue_valid_q <= 1'b0;
            issue_index_q <= 16'd0;
            issue_mask_q  <= '0;
            issue_last_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            best_value_q  <= 14'h3FFF;
            best_index_q  <= 16'hFFFF;
        end else begin
            state_q       <= state_d;
            total_q       <= total_d;
            issue_valid_q <= issue_valid_d;
            issue_index_q <= issue_index_d;
            issue_mask_q  <= issue_mask_d;
            issue_last_q  <= issue_last_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            best_value_q  <= best_value_d;
            best_index_q  <= best_index_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_index = issue_index_q;
    assign issue_mask  = issue_mask_q;
    assign issue_last  = issue_last_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign best_value  = best_value_q;
    assign best_index  = best_index_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// tb_sad_search_ctrl
// ---------------------------------------------------------------------------
// Self-checking bench for sad_search_ctrl. A fixed-latency SAD pipeline model
// returns one result beat per issued beat; candidate values come from the
// table vals[] (index modulo 1024). The reference answer is the lexicographic
// minimum of (vals[i], i) over 0 <= i < total_count, and the beat sequence is
// derived directly from ceil(total_count/4) and the lane rule base+k < total.
// ---------------------------------------------------------------------------
module tb_sad_search_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] total_count;
    logic        issue_valid;
    logic [15:0] issue_index;
    logic [3:0]  issue_mask;
    logic        issue_last;
    logic        res_valid;
    logic [55:0] res_value;
    logic [63:0] res_index;
    logic        res_trigger;
    logic        busy;
    logic        done;
    logic [13:0] best_value;
    logic [15:0] best_index;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [13:0] vals [0:1023];

    sad_search_ctrl #(.NUM_LANES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .total_count (total_count),
        .issue_valid (issue_valid),
        .issue_index (issue_index),
        .issue_mask  (issue_mask),
        .issue_last  (issue_last),
        .res_valid   (res_valid),
        .res_value   (res_value),
        .res_index   (res_index),
        .res_trigger (res_trigger),
        .busy        (busy),
        .done        (done),
        .best_value  (best_value),
        .best_index  (best_index),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_issue_valid"}, issue_valid, 0);
        check_eq({tag, "_issue_index"}, issue_index, 0);
        check_eq({tag, "_issue_mask"},  issue_mask, 0);
        check_eq({tag, "_issue_last"},  issue_last, 0);
        check_eq({tag, "_busy"},        busy, 0);
        check_eq({tag, "_done"},        done, 0);
        check_eq({tag, "_best_value"},  best_value, 14'h3FFF);
        check_eq({tag, "_best_index"},  best_index, 16'hFFFF);
        check_eq({tag, "_state"},       dbg_state, 0);
    endtask

    task automatic fill_vals(input int lo, input int hi);
        for (int i = 0; i < 1024; i++) vals[i] = 14'($urandom_range(hi, lo));
    endtask

    // ---------------- driver + scoreboard for one search ----------------
    // lat       : result latency in cycles after the beat is observed
    // poke_start: pulse start two cycles into DRAIN
    // rst_at    : cycle (relative to first beat cycle = 1) to pulse rst_n, 0 = never
    task automatic run_search(input int total, input int lat, input bit poke_start,
                              input int rst_at);
        logic [20:0] exp_q[$];
        int          pipe_cyc[$];
        logic [15:0] pipe_base[$];
        bit          pipe_last[$];
        logic [13:0] exp_v;
        logic [15:0] exp_i;
        logic [20:0] e;
        logic [15:0] b16, idx;
        int          nbeats, rel, limit, done_due, done_cnt;
        bit          aborted, exp_valid;

        exp_q = {};
        for (int b = 0; b < total; b += 4) begin
            logic [3:0] m;
            m = '0;
            for (int k = 0; k < 4; k++) if (b + k < total) m[k] = 1'b1;
            b16 = 16'(b);
            exp_q.push_back({(b + 4 >= total) ? 1'b1 : 1'b0, m, b16});
        end
        nbeats = exp_q.size();

        exp_v = 14'h3FFF;
        exp_i = 16'hFFFF;
        for (int i = 0; i < total; i++) begin
            if (vals[i % 1024] < exp_v) begin
                exp_v = vals[i % 1024];
                exp_i = 16'(i);
            end
        end

        start       = 1'b1;
        total_count = 16'(total);
        step();
        rel      = 1;
        limit    = nbeats + lat + 30;
        done_due = (total == 0) ? 1 : -1;
        done_cnt = 0;
        aborted  = 1'b0;

        while (rel <= limit) begin
            start = 1'b0;
            rst_n = 1'b1;

            // observe
            exp_valid = !aborted && rel <= nbeats;
            check_eq("issue_valid", issue_valid, exp_valid);
            if (exp_valid) begin
                e = exp_q[rel-1];
                check_eq("issue_index", issue_index, e[15:0]);
                check_eq("issue_mask",  issue_mask,  e[19:16]);
                check_eq("issue_last",  issue_last,  e[20]);
                pipe_cyc.push_back(rel + lat);
                pipe_base.push_back(e[15:0]);
                pipe_last.push_back(e[20]);
            end else begin
                check_eq("idle_mask", issue_mask, 0);
                check_eq("idle_last", issue_last, 0);
            end
            check_eq("done", done, (!aborted && rel == done_due));
            check_eq("busy", busy, (!aborted && (done_due < 0 || rel < done_due)));
            if (done) done_cnt++;
            if (aborted && rel == rst_at + 1) check_reset_outputs("mid_reset");

            // drive result beat from the latency model
            res_valid   = 1'b0;
            res_trigger = 1'b0;
            res_value   = '0;
            res_index   = '0;
            if (pipe_cyc.size() > 0 && pipe_cyc[0] == rel) begin
                void'(pipe_cyc.pop_front());
                b16 = pipe_base.pop_front();
                res_valid   = 1'b1;
                res_trigger = pipe_last.pop_front();
                for (int k = 0; k < 4; k++) begin
                    idx = b16 + 16'(k);
                    res_index[16*k +: 16] = idx;
                    res_value[14*k +: 14] = vals[idx[9:0]];
                end
                if (res_trigger && !aborted) done_due = rel + 1;
            end

            if (poke_start && rel == nbeats + 2) begin
                start       = 1'b1;
                total_count = 16'($urandom_range(100, 1));
            end
            if (rst_at != 0 && rel == rst_at) begin
                rst_n   = 1'b0;
                start   = 1'b1;  // must be discarded along with the reset
                aborted = 1'b1;
            end

            if (done_due > 0 && rel > done_due + 3) break;
            if (aborted && pipe_cyc.size() == 0 && rel > rst_at + 4) break;
            step();
            rel++;
        end
        start = 1'b0;
        rst_n = 1'b1;

        check_eq("done_count", done_cnt, aborted ? 0 : 1);
        check_eq("end_busy",   busy, 0);
        check_eq("best_value", best_value, aborted ? 14'h3FFF : exp_v);
        check_eq("best_index", best_index, aborted ? 16'hFFFF : exp_i);
        step();
        step();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        total_count = '0;
        res_valid   = 1'b0;
        res_value   = '0;
        res_index   = '0;
        res_trigger = 1'b0;
        for (int i = 0; i < 1024; i++) vals[i] = 14'd100;
        step();
        step();
        check_reset_outputs("por");
        rst_n = 1'b1;
        step();

        // ten candidates, three beats, 6-cycle pipeline
        fill_vals(10, 900);
        run_search(10, 6, 1'b0, 0);

        // ties resolve to the lower index
        for (int i = 0; i < 1024; i++) vals[i] = 14'd100;
        vals[0] = 14'd50; vals[1] = 14'd20; vals[2] = 14'd20; vals[3] = 14'd90;
        run_search(12, 4, 1'b0, 0);
        check_eq("tie_value_20", best_value, 14'd20);
        check_eq("tie_index_1",  best_index, 16'd1);

        // empty search
        run_search(0, 3, 1'b0, 0);

        // lane index 6 is beyond total_count=5, so its zero value must not win
        fill_vals(10, 500);
        vals[6] = 14'd0;
        run_search(5, 5, 1'b0, 0);
        check_eq("ignored_lane6", best_index == 16'd6, 0);

        // start pulse during DRAIN is ignored
        fill_vals(0, 63);
        run_search(9, 6, 1'b1, 0);

        // reset in the middle of ISSUE, with late result beats afterwards
        fill_vals(0, 63);
        run_search(40, 3, 1'b0, 4);

        // single-beat searches
        fill_vals(0, 15);
        run_search(3, 1, 1'b0, 0);
        run_search(4, 2, 1'b0, 0);

        // randomized searches with dense ties
        for (int t = 0; t < 8; t++) begin
            fill_vals(0, 31);
            run_search($urandom_range(120, 1), $urandom_range(8, 1),
                       1'($urandom_range(1, 0)), 0);
        end

        // index arithmetic near the top of the 16-bit range
        fill_vals(5, 2000);
        run_search(16'hFFFF, 3, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
